// File: rtl/count_sequencer.sv
// Run/pause/done counting sequencer: counts 0..N (or N..0) for a latched number of periods.
// Optional macro COUNT_DOWN_EN enables the down-count direction latched at start.
module count_sequencer (
    input  logic       clock,
    input  logic       clear,
    input  logic       start,
    input  logic       stop,
    input  logic       hold,
    input  logic [3:0] modulus,
    input  logic [3:0] periods,
    input  logic       down,
    output logic [3:0] q,
    output logic       tc,
    output logic       busy,
    output logic       done,
    output logic [3:0] period_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] mod_q, mod_d, per_q, per_d, q_q, q_d, cnt_q, cnt_d;
    logic       dn_q, dn_d, tc_q, tc_d, busy_q, busy_d, done_q, done_d;
    logic [3:0] start_val_s, term_val_s, term_next_s, cnt_inc_s;
    logic       at_term_s, last_s, launch_s;

    assign launch_s = (state_q == S_IDLE) && start && !stop;

`ifdef COUNT_DOWN_EN
    assign dn_d = launch_s ? down : dn_q;
`else
    logic unused_down_s;
    assign unused_down_s = down;
    assign dn_d          = 1'b0;
`endif

    assign start_val_s = dn_q ? mod_q : 4'd0;
    assign term_val_s  = dn_q ? 4'd0 : mod_q;
    assign at_term_s   = (q_q == term_val_s);
    assign cnt_inc_s   = cnt_q + 4'd1;
    assign last_s      = (per_q != 4'd0) && (cnt_inc_s == per_q);
    assign term_next_s = dn_d ? 4'd0 : mod_d;

    // State, datapath and registered outputs
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= S_IDLE;
            mod_q   <= 4'd0;
            per_q   <= 4'd0;
            q_q     <= 4'd0;
            cnt_q   <= 4'd0;
            dn_q    <= 1'b0;
            tc_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mod_q   <= mod_d;
            per_q   <= per_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            dn_q    <= dn_d;
            tc_q    <= tc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; stop outranks hold, hold outranks the wrap
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (launch_s) state_d = S_RUN;
                else          state_d = S_IDLE;
            end
            S_RUN: begin
                if (stop)                   state_d = S_IDLE;
                else if (hold)              state_d = S_PAUSE;
                else if (at_term_s && last_s) state_d = S_DONE;
                else                        state_d = S_RUN;
            end
            S_PAUSE: begin
                if (stop)       state_d = S_IDLE;
                else if (!hold) state_d = S_RUN;
                else            state_d = S_PAUSE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and output next values, derived from the upcoming state
    always_comb begin
        mod_d = mod_q;
        per_d = per_q;
        q_d   = q_q;
        cnt_d = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (launch_s) begin
                    mod_d = modulus;
                    per_d = periods;
                    q_d   = dn_d ? modulus : 4'd0;
                    cnt_d = 4'd0;
                end else begin
                    q_d = q_q;
                end
            end
            S_RUN: begin
                if (stop || hold) begin
                    q_d = q_q;
                end else if (at_term_s) begin
                    cnt_d = cnt_inc_s;
                    q_d   = last_s ? q_q : start_val_s;
                end else begin
                    q_d = dn_q ? (q_q - 4'd1) : (q_q + 4'd1);
                end
            end
            default: q_d = q_q;
        endcase
        tc_d   = (state_d == S_RUN) && (q_d == term_next_s);
        busy_d = (state_d == S_RUN) || (state_d == S_PAUSE);
        done_d = (state_d == S_DONE);
    end

    assign q          = q_q;
    assign tc         = tc_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign period_cnt = cnt_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Self-checking bench for count_sequencer: directed cases plus random stimulus against a behavioural model.
module tb_count_sequencer;

    logic       clock = 1'b0;
    logic       clear = 1'b0;
    logic       start = 1'b0;
    logic       stop  = 1'b0;
    logic       hold  = 1'b0;
    logic       down  = 1'b0;
    logic [3:0] modulus = 4'd0;
    logic [3:0] periods = 4'd0;
    logic [3:0] q, period_cnt;
    logic       tc, busy, done;

    int checks = 0;
    int errors = 0;
    int tc_seen = 0;
    int done_seen = 0;

    // behavioural model: "active" run flag, pause flag, one-shot completion flag
    bit m_active, m_paused, m_fin, m_dn;
    int m_q, m_cnt, m_n, m_p;

    count_sequencer dut (
        .clock(clock), .clear(clear), .start(start), .stop(stop), .hold(hold),
        .modulus(modulus), .periods(periods), .down(down),
        .q(q), .tc(tc), .busy(busy), .done(done), .period_cnt(period_cnt)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int m_term();
        return m_dn ? 0 : m_n;
    endfunction

    function automatic int m_first();
        return m_dn ? m_n : 0;
    endfunction

    task automatic model_reset();
        m_active = 0; m_paused = 0; m_fin = 0; m_dn = 0;
        m_q = 0; m_cnt = 0; m_n = 0; m_p = 0;
    endtask

    task automatic model_step();
        if (m_fin) begin
            m_fin = 0;
        end else if (!m_active) begin
            if (start && !stop) begin
                m_n = modulus;
                m_p = periods;
`ifdef COUNT_DOWN_EN
                m_dn = down;
`else
                m_dn = 0;
`endif
                m_q = m_first();
                m_cnt = 0;
                m_active = 1;
                m_paused = 0;
            end
        end else if (stop) begin
            m_active = 0;
            m_paused = 0;
        end else if (m_paused) begin
            if (!hold) m_paused = 0;
        end else if (hold) begin
            m_paused = 1;
        end else if (m_q == m_term()) begin
            m_cnt = (m_cnt + 1) % 16;
            if (m_p != 0 && m_cnt == m_p) begin
                m_active = 0;
                m_fin = 1;
            end else begin
                m_q = m_first();
            end
        end else begin
            m_q = m_dn ? m_q - 1 : m_q + 1;
        end
    endtask

    task automatic compare_all(input string ph);
        check({ph, "_q"}, q, m_q[3:0]);
        check({ph, "_tc"}, tc, (m_active && !m_paused && m_q == m_term()) ? 1 : 0);
        check({ph, "_busy"}, busy, m_active ? 1 : 0);
        check({ph, "_done"}, done, m_fin ? 1 : 0);
        check({ph, "_pcnt"}, period_cnt, m_cnt[3:0]);
    endtask

    task automatic cyc(input string ph);
        @(posedge clock);
        model_step();
        #1;
        compare_all(ph);
        tc_seen += int'(tc);
        done_seen += int'(done);
    endtask

    task automatic pulse_clear(input string ph);
        clear = 1'b0;
        #1;
        model_reset();
        compare_all(ph);
        clear = 1'b1;
    endtask

    task automatic launch(input logic [3:0] n, input logic [3:0] p, input logic d, input string ph);
        modulus = n; periods = p; down = d; start = 1'b1;
        cyc(ph);
        start = 1'b0;
    endtask

    initial begin
        model_reset();
        #2;
        compare_all("reset");
        clear = 1'b1;

        // terminal count 9, single period
        tc_seen = 0; done_seen = 0;
        launch(4'd9, 4'd1, 1'b0, "c9");
        repeat (12) cyc("c9");
        check("c9_tc_count", tc_seen, 1);
        check("c9_done_count", done_seen, 1);
        check("c9_q_end", q, 9);

        // pause for three cycles at q=2
        tc_seen = 0; done_seen = 0;
        launch(4'd3, 4'd2, 1'b0, "c3");
        repeat (2) cyc("c3");
        hold = 1'b1;
        repeat (3) cyc("c3h");
        hold = 1'b0;
        repeat (12) cyc("c3");
        check("c3_done_count", done_seen, 1);
        check("c3_pcnt_end", period_cnt, 2);

        // free-running mod 15, then stop
        tc_seen = 0; done_seen = 0;
        launch(4'd15, 4'd0, 1'b0, "c15");
        repeat (39) cyc("c15");
        check("c15_tc_count", tc_seen, 2);
        stop = 1'b1;
        cyc("c15s");
        stop = 1'b0;
        check("c15_done_count", done_seen, 0);
        check("c15_busy_after_stop", busy, 0);

        // clear mid-run at q=5
        launch(4'd9, 4'd0, 1'b0, "clr");
        repeat (5) cyc("clr");
        check("clr_q_before", q, 5);
        pulse_clear("clr_async");
        check("clr_q_zero", q, 0);
        launch(4'd9, 4'd0, 1'b0, "clr_restart");
        check("clr_restart_q", q, 0);
        check("clr_restart_busy", busy, 1);
        stop = 1'b1;
        cyc("clr_stop");
        stop = 1'b0;

        // N = 0, three periods
        tc_seen = 0; done_seen = 0;
        launch(4'd0, 4'd3, 1'b0, "n0");
        repeat (6) cyc("n0");
        check("n0_tc_count", tc_seen, 3);
        check("n0_done_count", done_seen, 1);

        // start and stop together in IDLE
        stop = 1'b1;
        launch(4'd5, 4'd1, 1'b0, "ss");
        stop = 1'b0;
        check("ss_busy", busy, 0);

`ifdef COUNT_DOWN_EN
        tc_seen = 0; done_seen = 0;
        launch(4'd4, 4'd1, 1'b1, "dn");
        check("dn_first_q", q, 4);
        repeat (6) cyc("dn");
        check("dn_tc_count", tc_seen, 1);
        check("dn_done_count", done_seen, 1);
        check("dn_q_end", q, 0);
        down = 1'b0;
`endif

        // random stimulus, including mid-run input changes and occasional clears
        for (int i = 0; i < 3000; i++) begin
            start   = ($urandom_range(0, 7) == 0);
            stop    = ($urandom_range(0, 39) == 0);
            hold    = ($urandom_range(0, 5) == 0);
            modulus = 4'($urandom_range(0, 15));
            periods = 4'($urandom_range(0, 3));
            down    = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 199) == 0) pulse_clear("rnd_clr");
            cyc("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/count_sequencer.md
COUNT_SEQUENCER -- requirements
Module: count_sequencer

Interface
REQ-001 The block SHALL have port: clock  in  1  sole clock, rising-edge active.
REQ-002 The block SHALL have port: clear  in  1  asynchronous active-low reset.
REQ-003 The block SHALL have port: start  in  1  request to begin a counting run; sampled only in IDLE.
REQ-004 The block SHALL have port: stop  in  1  abort the run and return to IDLE.
REQ-005 The block SHALL have port: hold  in  1  freeze the count while high, during RUN only.
REQ-006 The block SHALL have port: modulus  in  4  terminal count N; the count sequence is 0..N, then wraps.
REQ-007 The block SHALL have port: periods  in  4  number of full 0..N periods per run; 0 means run until stop.
REQ-008 The block SHALL have port: down  in  1  count direction select; effective only when COUNT_DOWN_EN is defined.
REQ-009 The block SHALL have port: q  out  4  current count value.
REQ-010 The block SHALL have port: tc  out  1  one-cycle pulse in the cycle q equals the terminal value.
REQ-011 The block SHALL have port: busy  out  1  high in RUN and PAUSE.
REQ-012 The block SHALL have port: done  out  1  one-cycle pulse on completion of the final period.
REQ-013 The block SHALL have port: period_cnt  out  4  number of completed periods in the current run.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, RUN, PAUSE, DONE; all outputs are registered.
REQ-015 IDLE: start=1 SHALL latch modulus and periods, load q with the start value, clear period_cnt, and enter RUN on the next edge.
REQ-016 The start value and terminal value SHALL be 0 and N for up counting, and N and 0 for down counting.
REQ-017 RUN: q SHALL step by one per clock edge; at the terminal value, the next edge SHALL reload the start value and increment period_cnt.
REQ-018 tc SHALL be high exactly in the cycles where busy=1 and q equals the terminal value.
REQ-019 When N=0, q SHALL stay 0, tc SHALL stay high for every RUN cycle, and each cycle SHALL count as one period.
REQ-020 In RUN with hold=1, the next edge SHALL enter PAUSE with q frozen; in PAUSE with hold=0, the next edge SHALL return to RUN.
REQ-021 In PAUSE, tc SHALL be 0 even when q equals the terminal value.
REQ-022 When periods=P≠0 and the wrap completes period P, the next state SHALL be DONE, with q=terminal value held and period_cnt=P.
REQ-023 DONE SHALL last exactly one cycle with done=1 and busy=0, then go to IDLE; q and period_cnt SHALL hold their values until the next start.
REQ-024 When periods=0, period_cnt SHALL wrap 15→0 and done SHALL never assert.
REQ-025 stop=1 in RUN or PAUSE SHALL force IDLE on the next edge without asserting done; stop SHALL take priority over hold and wrap.
REQ-026 start in RUN, PAUSE or DONE SHALL be ignored; changes to modulus or periods mid-run SHALL have no effect until the next start.
REQ-027 start and stop both high in IDLE SHALL leave the block in IDLE.

Reset
REQ-028 clear=0 SHALL immediately force IDLE, q=0, period_cnt=0, tc=0, busy=0, done=0, independent of clock.
REQ-029 Deassertion of clear SHALL take effect at the next rising clock edge; the first start SHALL be honoured on that edge.
REQ-030 Reset mid-run SHALL discard the run; latched modulus and periods SHALL be reset to 0.

Configuration
REQ-031 With COUNT_DOWN_EN defined, down SHALL be latched at start, and down=1 SHALL count N, N-1, ..., 0 with 0 as the terminal value.
REQ-032 Without COUNT_DOWN_EN, the down input SHALL be ignored and the block SHALL count up only; all other behaviour SHALL be identical.

Verification
REQ-033 Bench case: modulus=9, periods=1, start pulse -> q 0..9 in consecutive cycles, tc at q=9, then a one-cycle done, then IDLE with q=9.
REQ-034 Bench case: modulus=3, periods=2, hold high for 3 cycles at q=2 -> q stays 2 for 3 cycles with tc=0, resumes, done after period_cnt reaches 2.
REQ-035 Bench case: modulus=15, periods=0, run 40 cycles, then stop -> tc every 16 cycles, no done, IDLE one cycle after stop.
REQ-036 Bench case: clear pulsed low mid-run at q=5 -> all outputs 0 immediately; the next start restarts from q=0.
REQ-037 Bench case: modulus=0, periods=3 -> tc high for 3 RUN cycles, then done.
REQ-038 Bench case: with COUNT_DOWN_EN defined, down=1, modulus=4, periods=1 -> q 4,3,2,1,0, tc at 0, then done.
